// File: rtl/lsu_mem_req.sv
// lsu_mem_req: load/store unit front-end in front of the NPC memory controller.
// It takes one core request at a time and checks alignment and size. Legal
// requests become one word-aligned, byte-masked access that holds mem_valid
// high for LATENCY cycles. Load data is lane-shifted and extended into
// resp_rdata. Illegal requests skip memory entirely and answer with resp_err.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake from the memory stage
//   req_wen, req_addr,         store flag, byte address, right-aligned store
//   req_wdata, req_size,       data, size (0 byte, 1 half, 2 word, 3 illegal),
//   req_unsigned               zero-extend loads
//   resp_valid/resp_ready      response handshake back to the core
//   resp_rdata, resp_err       extended load data (0 for stores/errors), error
//   mem_valid, mem_wen         access strobes to the memory controller
//   mem_raddr, mem_waddr       word-aligned access address
//   mem_wdata, mem_wmask       lane-shifted store data and byte mask
//   mem_rdata                  read data from the memory controller
module lsu_mem_req #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    output logic        mem_wen,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    // state  | meaning
    // IDLE   | waiting for a request, req_ready high once out of reset
    // ACCESS | mem_valid high, counting down the memory latency
    // RESP   | response presented, waiting for resp_ready
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        init_done;

    logic        wen_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic        accept;
    logic        legal;
    logic        sample;
    logic [3:0]  wmask_fmt;
    logic [31:0] wdata_fmt;
    logic [31:0] rdata_shift;
    logic [31:0] rdata_ext;

    always_comb begin
        case (req_size)
            2'd0:    legal = 1'b1;
            2'd1:    legal = ~req_addr[0];
            2'd2:    legal = (req_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        case (req_size)
            2'd0:    wmask_fmt = 4'b0001 << req_addr[1:0];
            2'd1:    wmask_fmt = 4'b0011 << req_addr[1:0];
            default: wmask_fmt = 4'b1111;
        endcase
        wdata_fmt = req_wdata << {req_addr[1:0], 3'b000};
    end

    always_comb begin
        rdata_shift = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    rdata_ext = {{24{rdata_shift[7] & ~uns_q}}, rdata_shift[7:0]};
            2'd1:    rdata_ext = {{16{rdata_shift[15] & ~uns_q}}, rdata_shift[15:0]};
            default: rdata_ext = mem_rdata;
        endcase
    end

    // init_done keeps req_ready low until the first edge after reset release.
    assign req_ready  = init_done && (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign mem_valid  = (state == ACCESS);
    assign mem_wen    = (state == ACCESS) && wen_q;
    assign resp_valid = (state == RESP);
    assign sample     = (state == ACCESS) && (cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            init_done <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (legal) begin
                        state_nxt = ACCESS;
                        cnt_nxt   = CNT_INIT;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields and memory-side outputs. The mem_* buses only load on a
    // legal accept, so they keep their last values outside ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q      <= 1'b0;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_raddr  <= 32'd0;
            mem_waddr  <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_wmask  <= 8'd0;
        end else begin
            if (accept) begin
                wen_q      <= req_wen;
                off_q      <= req_addr[1:0];
                size_q     <= req_size;
                uns_q      <= req_unsigned;
                resp_rdata <= 32'd0;
                resp_err   <= ~legal;
                if (legal) begin
                    mem_raddr <= {req_addr[31:2], 2'b00};
                    mem_waddr <= {req_addr[31:2], 2'b00};
                    mem_wdata <= wdata_fmt;
                    mem_wmask <= {4'b0000, wmask_fmt};
                end
            end else if (resp_valid && resp_ready) begin
                resp_err <= 1'b0;
            end
            if (sample && !wen_q) begin
                resp_rdata <= rdata_ext;
            end
        end
    end

endmodule

// File: doc/lsu_mem_req.md
Name: lsu_mem_req

Overview:
- Load/store unit front-end that sits directly upstream of the DPI memory controller (MemContrl) in the NPC.
- Accepts one load/store request at a time from the core's memory stage. Issues a word-aligned access with a byte mask to the memory controller.
- Captures read data, then byte-lane shifts and sign/zero-extends it.
- Returns a response through a valid/ready handshake and flags misaligned accesses without touching memory.

Parameters:
- LATENCY, 1: cycles mem_valid is held high per access; mem_rdata is sampled on the clock edge that ends the last such cycle. Legal range 1..15.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  core request valid
- req_ready  output  1  block can accept a request
- req_wen  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  input  1  load zero-extends when 1
- resp_valid  output  1  response valid
- resp_ready  input  1  core accepts response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned or illegal-size request
- mem_valid  output  1  to MemContrl valid
- mem_wen  output  1  to MemContrl wen
- mem_raddr  output  32  word-aligned read address
- mem_waddr  output  32  word-aligned write address
- mem_wdata  output  32  lane-shifted store data
- mem_wmask  output  8  byte mask; bits [7:4] always 0
- mem_rdata  input  32  from MemContrl rdata

Behaviour:
- Reset (rst_n low, asynchronous) clears all state and outputs:
  - FSM goes to IDLE.
  - req_ready, resp_valid, resp_err, mem_valid and mem_wen are 0.
  - All data, address and mask outputs are 0.
  - req_ready rises on the first clk edge after reset release.
- Reset mid-transaction aborts the transaction with no response. mem_valid drops immediately.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch wen, addr, wdata, size and unsigned.
  - If the request is legal, go to ACCESS and load the latency counter with LATENCY-1.
  - If illegal, go straight to RESP with resp_err = 1.
- Legality rules:
  - size 3 is illegal.
  - half with addr[0] = 1 is illegal.
  - word with addr[1:0] != 0 is illegal.
  - byte is always legal.
- ACCESS:
  - mem_valid = 1 and mem_wen = latched wen.
  - mem_raddr = mem_waddr = {addr[31:2], 2'b00}.
  - The counter decrements each cycle. When it reaches 0, sample mem_rdata (loads only) and go to RESP.
  - req_ready = 0.
- Store lane formatting, with off = addr[1:0]:
  - wmask = 4'b0001 << off (byte), 4'b0011 << off (half), 4'b1111 (word).
  - wdata = req_wdata << (8*off).
- Load formatting:
  - shifted = mem_rdata >> (8*off).
  - Byte loads take bits [7:0] and half loads take bits [15:0].
  - Sign-extend unless req_unsigned = 1. Word loads pass through unchanged.
- RESP:
  - resp_valid = 1. resp_rdata and resp_err are held stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE; resp_valid and resp_err drop the next cycle.
  - mem_valid = 0 and mem_wen = 0.
- mem_valid is guaranteed low for at least one cycle between accesses, because the downstream controller is triggered by valid/wen changes.
- mem_* address, data and mask outputs hold their last values outside ACCESS; only mem_valid and mem_wen qualify them.
- Latency: request accepted at edge E; mem_valid high for cycles E+1..E+LATENCY; resp_valid first seen in cycle E+LATENCY+1. For an error request, resp_valid is seen in cycle E+1.
- Throughput is one outstanding request. A new request is accepted no earlier than the cycle after the response handshake.
- req_valid is ignored outside IDLE. resp_ready is ignored outside RESP.

Test Plan:
- Word load, LATENCY=1, addr 0x80000004, mem_rdata 0xDEADBEEF:
  - mem_valid=1, mem_wen=0, mem_raddr=0x80000004 for one cycle.
  - resp_rdata=0xDEADBEEF, resp_err=0, resp_valid the cycle after.
- Signed byte load at addr 0x80000003, mem_rdata 0x80FF1234:
  - resp_rdata=0xFFFFFF80.
  - Same with req_unsigned=1 gives 0x00000080.
- Half store at addr 0x80000002, wdata 0x0000ABCD:
  - mem_wen=1, mem_waddr=0x80000000, mem_wmask=0x0C, mem_wdata=0xABCD0000.
  - resp_rdata=0.
- Misaligned word load at 0x80000001 and size=3 request:
  - mem_valid never asserts.
  - resp_valid the cycle after accept, resp_err=1, resp_rdata=0.
- LATENCY=3 with resp_ready held low for 4 cycles after resp_valid:
  - mem_valid high for exactly 3 cycles.
  - resp_* stable all 4 cycles; req_ready=0 until the handshake completes.
  - Back-to-back requests show mem_valid low for at least one cycle between accesses.
- rst_n pulsed low during ACCESS:
  - mem_valid and resp_valid drop asynchronously and no response is produced.
  - req_ready=1 on the first edge after release; a fresh load completes normally.
